scheduler2_alu_rsv_station: RTL and testbench

SCHEDULER2_ALU_RSV_STATION -- requirements
Module: scheduler2_alu_rsv_station

---
 rtl/scheduler2_alu_rsv_station_pkg.sv | 18 +
 rtl/scheduler2_alu_rsv_station_entry_wakeup.sv | 27 ++
 rtl/scheduler2_alu_rsv_station.sv | 177 +++++++++++++++++
 tb/tb_scheduler2_alu_rsv_station.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scheduler2_alu_rsv_station_pkg.sv
// Shared scheduler definitions: default geometry and entry-field widths
// used by the ALU reservation station and its per-entry wakeup logic.
package scheduler2_alu_rsv_station_pkg;

  localparam int SCHED_ENTRY_N_DEF   = 8;
  localparam int SCHED_PAYLOAD_W_DEF = 64;
  localparam int SCHED_TAG_W_DEF     = 6;
  localparam int SCHED_COUNT_W       = 4;
  localparam int SCHED_SRC_N         = 2;
  localparam int SCHED_WAKEUP_N      = 2;

  // A station is reported full once fewer than two slots remain free,
  // so a dual-slot allocation can never be partially dropped.
  function automatic logic schedIsFull(input int entryN, input int count);
    return (entryN - count) < 2;
  endfunction

endpackage

// File: rtl/scheduler2_alu_rsv_station_entry_wakeup.sv
// Per-entry source wakeup: compares both stored source tags against the
// result-tag broadcasts and returns the updated ready flags.
module scheduler2_rsv_entry_wakeup
  import scheduler2_alu_rsv_station_pkg::*;
#(
  parameter int P_TAG_W = SCHED_TAG_W_DEF
) (
  input  logic [SCHED_SRC_N-1:0]                 srcRdy,
  input  logic [SCHED_SRC_N-1:0][P_TAG_W-1:0]    srcTag,
  input  logic [SCHED_WAKEUP_N-1:0]              wakeupValid,
  input  logic [SCHED_WAKEUP_N-1:0][P_TAG_W-1:0] wakeupTag,
  output logic [SCHED_SRC_N-1:0]                 srcRdyNext
);

  // A source becomes ready when any valid broadcast carries its tag; ready stays sticky.
  always_comb begin
    srcRdyNext = srcRdy;
    for (int j = 0; j < SCHED_SRC_N; j++) begin
      for (int m = 0; m < SCHED_WAKEUP_N; m++) begin
        if (wakeupValid[m] && (wakeupTag[m] == srcTag[j])) begin
          srcRdyNext[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scheduler2_alu_rsv_station.sv
// ALU reservation station: age-ordered compacting queue with dual-slot
// allocation, two wakeup broadcasts and oldest-ready-first single issue.
module scheduler2_alu_rsv_station
  import scheduler2_alu_rsv_station_pkg::*;
#(
  parameter int P_ENTRY_N   = SCHED_ENTRY_N_DEF,
  parameter int P_PAYLOAD_W = SCHED_PAYLOAD_W_DEF,
  parameter int P_TAG_W     = SCHED_TAG_W_DEF
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET_SYNC,
  input  logic                     iFLUSH,
  input  logic                     iALLOC_0_VALID,
  input  logic [P_PAYLOAD_W-1:0]   iALLOC_0_PAYLOAD,
  input  logic                     iALLOC_0_SRC0_RDY,
  input  logic                     iALLOC_0_SRC1_RDY,
  input  logic [P_TAG_W-1:0]       iALLOC_0_SRC0_TAG,
  input  logic [P_TAG_W-1:0]       iALLOC_0_SRC1_TAG,
  input  logic                     iALLOC_1_VALID,
  input  logic [P_PAYLOAD_W-1:0]   iALLOC_1_PAYLOAD,
  input  logic                     iALLOC_1_SRC0_RDY,
  input  logic                     iALLOC_1_SRC1_RDY,
  input  logic [P_TAG_W-1:0]       iALLOC_1_SRC0_TAG,
  input  logic [P_TAG_W-1:0]       iALLOC_1_SRC1_TAG,
  input  logic                     iWAKEUP_0_VALID,
  input  logic [P_TAG_W-1:0]       iWAKEUP_0_TAG,
  input  logic                     iWAKEUP_1_VALID,
  input  logic [P_TAG_W-1:0]       iWAKEUP_1_TAG,
  output logic                     oISSUE_VALID,
  output logic [P_PAYLOAD_W-1:0]   oISSUE_PAYLOAD,
  input  logic                     iISSUE_BUSY,
  output logic [SCHED_COUNT_W-1:0] oCOUNT,
  output logic                     oFULL
);

  logic [P_ENTRY_N-1:0]                        entValid;
  logic [P_PAYLOAD_W-1:0]                      entPayload  [P_ENTRY_N];
  logic [SCHED_SRC_N-1:0]                      entRdy      [P_ENTRY_N];
  logic [SCHED_SRC_N-1:0][P_TAG_W-1:0]         entTag      [P_ENTRY_N];
  logic [SCHED_SRC_N-1:0]                      entRdyWoken [P_ENTRY_N];
  logic [SCHED_COUNT_W-1:0]                    countQ;
  logic                                        fullQ;

  logic [SCHED_WAKEUP_N-1:0]                   wakeupValid;
  logic [SCHED_WAKEUP_N-1:0][P_TAG_W-1:0]      wakeupTag;
  logic [1:0]                                  allocValid;
  logic [P_PAYLOAD_W-1:0]                      allocPayload  [2];
  logic [SCHED_SRC_N-1:0]                      allocRdy      [2];
  logic [SCHED_SRC_N-1:0][P_TAG_W-1:0]         allocTag      [2];
  logic [SCHED_SRC_N-1:0]                      allocRdyWoken [2];

  logic                                        issueValid;
  logic                                        issueFire;
  int                                          selIdx;

  logic [P_ENTRY_N-1:0]                        nxtValid;
  logic [P_PAYLOAD_W-1:0]                      nxtPayload [P_ENTRY_N];
  logic [SCHED_SRC_N-1:0]                      nxtRdy     [P_ENTRY_N];
  logic [SCHED_SRC_N-1:0][P_TAG_W-1:0]         nxtTag     [P_ENTRY_N];
  logic [SCHED_COUNT_W-1:0]                    countD;
  logic                                        fullD;

  assign wakeupValid     = {iWAKEUP_1_VALID, iWAKEUP_0_VALID};
  assign wakeupTag       = {iWAKEUP_1_TAG, iWAKEUP_0_TAG};
  assign allocValid      = {iALLOC_1_VALID, iALLOC_0_VALID};
  assign allocPayload[0] = iALLOC_0_PAYLOAD;
  assign allocPayload[1] = iALLOC_1_PAYLOAD;
  assign allocRdy[0]     = {iALLOC_0_SRC1_RDY, iALLOC_0_SRC0_RDY};
  assign allocRdy[1]     = {iALLOC_1_SRC1_RDY, iALLOC_1_SRC0_RDY};
  assign allocTag[0]     = {iALLOC_0_SRC1_TAG, iALLOC_0_SRC0_TAG};
  assign allocTag[1]     = {iALLOC_1_SRC1_TAG, iALLOC_1_SRC0_TAG};

  for (genvar gi = 0; gi < P_ENTRY_N; gi++) begin : gEntryWakeup
    scheduler2_rsv_entry_wakeup #(.P_TAG_W(P_TAG_W)) uWakeup (
      .srcRdy      (entRdy[gi]),
      .srcTag      (entTag[gi]),
      .wakeupValid (wakeupValid),
      .wakeupTag   (wakeupTag),
      .srcRdyNext  (entRdyWoken[gi])
    );
  end

  for (genvar gk = 0; gk < 2; gk++) begin : gAllocWakeup
    scheduler2_rsv_entry_wakeup #(.P_TAG_W(P_TAG_W)) uWakeup (
      .srcRdy      (allocRdy[gk]),
      .srcTag      (allocTag[gk]),
      .wakeupValid (wakeupValid),
      .wakeupTag   (wakeupTag),
      .srcRdyNext  (allocRdyWoken[gk])
    );
  end

  // Present the oldest entry whose both sources are ready in registered state.
  always_comb begin
    issueValid = 1'b0;
    selIdx     = 0;
    for (int i = 0; i < P_ENTRY_N; i++) begin
      if (!issueValid && entValid[i] && (&entRdy[i])) begin
        issueValid = 1'b1;
        selIdx     = i;
      end
    end
    oISSUE_PAYLOAD = entPayload[selIdx];
  end

  assign oISSUE_VALID = issueValid;
  assign issueFire    = issueValid && !iISSUE_BUSY;
  assign oCOUNT       = countQ;
  assign oFULL        = fullQ;

  // Compact out the issued entry, then append accepted allocations at the new tail.
  always_comb begin
    int  keptCount;
    int  freeCount;
    int  pos0;
    int  pos1;
    int  src;
    int  cntNext;
    logic take0;
    logic take1;
    nxtValid  = '0;
    keptCount = int'(countQ) - (issueFire ? 1 : 0);
    freeCount = P_ENTRY_N - keptCount;
    take0     = allocValid[0] && (freeCount >= 1);
    take1     = allocValid[1] && (freeCount >= (take0 ? 2 : 1));
    pos0      = keptCount;
    pos1      = keptCount + (take0 ? 1 : 0);
    cntNext   = keptCount + (take0 ? 1 : 0) + (take1 ? 1 : 0);
    for (int i = 0; i < P_ENTRY_N; i++) begin
      src           = (issueFire && (i >= selIdx)) ? i + 1 : i;
      nxtPayload[i] = entPayload[i];
      nxtRdy[i]     = entRdyWoken[i];
      nxtTag[i]     = entTag[i];
      if (src < P_ENTRY_N) begin
        nxtValid[i]   = entValid[src];
        nxtPayload[i] = entPayload[src];
        nxtRdy[i]     = entRdyWoken[src];
        nxtTag[i]     = entTag[src];
      end
      if (take0 && (i == pos0)) begin
        nxtValid[i]   = 1'b1;
        nxtPayload[i] = allocPayload[0];
        nxtRdy[i]     = allocRdyWoken[0];
        nxtTag[i]     = allocTag[0];
      end
      if (take1 && (i == pos1)) begin
        nxtValid[i]   = 1'b1;
        nxtPayload[i] = allocPayload[1];
        nxtRdy[i]     = allocRdyWoken[1];
        nxtTag[i]     = allocTag[1];
      end
    end
    countD = SCHED_COUNT_W'(cntNext);
    fullD  = schedIsFull(P_ENTRY_N, cntNext);
  end

  // Occupancy state: reset beats flush, flush beats allocation and issue.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFLUSH) begin
      entValid <= '0;
      countQ   <= '0;
      fullQ    <= 1'b0;
    end else begin
      entValid <= nxtValid;
      countQ   <= countD;
      fullQ    <= fullD;
    end
  end

  // Entry contents are qualified by entValid, so they need no reset.
  always_ff @(posedge iCLOCK) begin
    entPayload <= nxtPayload;
    entRdy     <= nxtRdy;
    entTag     <= nxtTag;
  end

endmodule

// File: tb/tb_scheduler2_alu_rsv_station.sv
// Directed bench for the ALU reservation station: allocation, wakeup,
// ordering, full/overflow, same-cycle issue+alloc, flush and reset.
module tb_scheduler2_alu_rsv_station;

  logic        iCLOCK;
  logic        iRESET_SYNC;
  logic        iFLUSH;
  logic        iALLOC_0_VALID;
  logic [63:0] iALLOC_0_PAYLOAD;
  logic        iALLOC_0_SRC0_RDY;
  logic        iALLOC_0_SRC1_RDY;
  logic [5:0]  iALLOC_0_SRC0_TAG;
  logic [5:0]  iALLOC_0_SRC1_TAG;
  logic        iALLOC_1_VALID;
  logic [63:0] iALLOC_1_PAYLOAD;
  logic        iALLOC_1_SRC0_RDY;
  logic        iALLOC_1_SRC1_RDY;
  logic [5:0]  iALLOC_1_SRC0_TAG;
  logic [5:0]  iALLOC_1_SRC1_TAG;
  logic        iWAKEUP_0_VALID;
  logic [5:0]  iWAKEUP_0_TAG;
  logic        iWAKEUP_1_VALID;
  logic [5:0]  iWAKEUP_1_TAG;
  logic        oISSUE_VALID;
  logic [63:0] oISSUE_PAYLOAD;
  logic        iISSUE_BUSY;
  logic [3:0]  oCOUNT;
  logic        oFULL;

  int checks = 0;
  int errors = 0;

  scheduler2_alu_rsv_station uDut (
    .iCLOCK            (iCLOCK),
    .iRESET_SYNC       (iRESET_SYNC),
    .iFLUSH            (iFLUSH),
    .iALLOC_0_VALID    (iALLOC_0_VALID),
    .iALLOC_0_PAYLOAD  (iALLOC_0_PAYLOAD),
    .iALLOC_0_SRC0_RDY (iALLOC_0_SRC0_RDY),
    .iALLOC_0_SRC1_RDY (iALLOC_0_SRC1_RDY),
    .iALLOC_0_SRC0_TAG (iALLOC_0_SRC0_TAG),
    .iALLOC_0_SRC1_TAG (iALLOC_0_SRC1_TAG),
    .iALLOC_1_VALID    (iALLOC_1_VALID),
    .iALLOC_1_PAYLOAD  (iALLOC_1_PAYLOAD),
    .iALLOC_1_SRC0_RDY (iALLOC_1_SRC0_RDY),
    .iALLOC_1_SRC1_RDY (iALLOC_1_SRC1_RDY),
    .iALLOC_1_SRC0_TAG (iALLOC_1_SRC0_TAG),
    .iALLOC_1_SRC1_TAG (iALLOC_1_SRC1_TAG),
    .iWAKEUP_0_VALID   (iWAKEUP_0_VALID),
    .iWAKEUP_0_TAG     (iWAKEUP_0_TAG),
    .iWAKEUP_1_VALID   (iWAKEUP_1_VALID),
    .iWAKEUP_1_TAG     (iWAKEUP_1_TAG),
    .oISSUE_VALID      (oISSUE_VALID),
    .oISSUE_PAYLOAD    (oISSUE_PAYLOAD),
    .iISSUE_BUSY       (iISSUE_BUSY),
    .oCOUNT            (oCOUNT),
    .oFULL             (oFULL)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic clearInputs();
    iRESET_SYNC       = 1'b0;
    iFLUSH            = 1'b0;
    iALLOC_0_VALID    = 1'b0;
    iALLOC_0_PAYLOAD  = '0;
    iALLOC_0_SRC0_RDY = 1'b0;
    iALLOC_0_SRC1_RDY = 1'b0;
    iALLOC_0_SRC0_TAG = '0;
    iALLOC_0_SRC1_TAG = '0;
    iALLOC_1_VALID    = 1'b0;
    iALLOC_1_PAYLOAD  = '0;
    iALLOC_1_SRC0_RDY = 1'b0;
    iALLOC_1_SRC1_RDY = 1'b0;
    iALLOC_1_SRC0_TAG = '0;
    iALLOC_1_SRC1_TAG = '0;
    iWAKEUP_0_VALID   = 1'b0;
    iWAKEUP_0_TAG     = '0;
    iWAKEUP_1_VALID   = 1'b0;
    iWAKEUP_1_TAG     = '0;
    iISSUE_BUSY       = 1'b0;
  endtask

  task automatic applySlot0(input logic v, input logic [63:0] p, input logic r0,
                            input logic [5:0] t0, input logic r1, input logic [5:0] t1);
    iALLOC_0_VALID    = v;
    iALLOC_0_PAYLOAD  = p;
    iALLOC_0_SRC0_RDY = r0;
    iALLOC_0_SRC0_TAG = t0;
    iALLOC_0_SRC1_RDY = r1;
    iALLOC_0_SRC1_TAG = t1;
  endtask

  task automatic applySlot1(input logic v, input logic [63:0] p, input logic r0,
                            input logic [5:0] t0, input logic r1, input logic [5:0] t1);
    iALLOC_1_VALID    = v;
    iALLOC_1_PAYLOAD  = p;
    iALLOC_1_SRC0_RDY = r0;
    iALLOC_1_SRC0_TAG = t0;
    iALLOC_1_SRC1_RDY = r1;
    iALLOC_1_SRC1_TAG = t1;
  endtask

  task automatic test_reset();
    clearInputs();
    iRESET_SYNC = 1'b1;
    tick();
    tick();
    iRESET_SYNC = 1'b0;
    checks++; if (oCOUNT !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", oCOUNT); end
    checks++; if (oFULL !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", oFULL); end
    checks++; if (oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", oISSUE_VALID); end
  endtask

  task automatic test_single();
    clearInputs();
    applySlot0(1'b1, 64'hA5, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    #1;
    checks++; if (oISSUE_VALID !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", oISSUE_VALID); end
    checks++; if (oISSUE_PAYLOAD !== 64'hA5) begin errors++; $display("[TB] FAIL single_payload got %h want a5", oISSUE_PAYLOAD); end
    checks++; if (oCOUNT !== 4'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", oCOUNT); end
    tick();
    checks++; if (oCOUNT !== 4'd1) begin errors++; $display("[TB] FAIL single_busy_hold got %0d want 1", oCOUNT); end
    iISSUE_BUSY = 1'b0;
    tick();
    checks++; if (oCOUNT !== 4'd0) begin errors++; $display("[TB] FAIL single_drain got %0d want 0", oCOUNT); end
    checks++; if (oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got %b want 0", oISSUE_VALID); end
  endtask

  task automatic test_wakeup_order();
    clearInputs();
    applySlot0(1'b1, 64'h11, 1'b0, 6'd5, 1'b1, 6'd0);
    applySlot1(1'b1, 64'h22, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    clearInputs();
    checks++; if (oCOUNT !== 4'd2) begin errors++; $display("[TB] FAIL order_count got %0d want 2", oCOUNT); end
    checks++; if (oISSUE_PAYLOAD !== 64'h22 || oISSUE_VALID !== 1'b1) begin errors++; $display("[TB] FAIL order_first got %b/%h want 1/22", oISSUE_VALID, oISSUE_PAYLOAD); end
    tick();
    checks++; if (oCOUNT !== 4'd1 || oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL order_waiting got %0d/%b want 1/0", oCOUNT, oISSUE_VALID); end
    iWAKEUP_0_VALID = 1'b1;
    iWAKEUP_0_TAG   = 6'd4;
    tick();
    checks++; if (oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL order_wrong_tag got %b want 0", oISSUE_VALID); end
    iWAKEUP_0_TAG = 6'd5;
    tick();
    iWAKEUP_0_VALID = 1'b0;
    checks++; if (oISSUE_PAYLOAD !== 64'h11 || oISSUE_VALID !== 1'b1) begin errors++; $display("[TB] FAIL order_woken got %b/%h want 1/11", oISSUE_VALID, oISSUE_PAYLOAD); end
    tick();
    checks++; if (oCOUNT !== 4'd0) begin errors++; $display("[TB] FAIL order_drain got %0d want 0", oCOUNT); end
  endtask

  task automatic test_busy_wakeup();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    applySlot0(1'b1, 64'h77, 1'b1, 6'd0, 1'b0, 6'd9);
    applySlot1(1'b1, 64'h66, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    applySlot0(1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0);
    applySlot1(1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0);
    checks++; if (oISSUE_PAYLOAD !== 64'h66) begin errors++; $display("[TB] FAIL busy_young got %h want 66", oISSUE_PAYLOAD); end
    iWAKEUP_1_VALID = 1'b1;
    iWAKEUP_1_TAG   = 6'd9;
    tick();
    iWAKEUP_1_VALID = 1'b0;
    checks++; if (oISSUE_PAYLOAD !== 64'h77 || oCOUNT !== 4'd2) begin errors++; $display("[TB] FAIL busy_older got %h/%0d want 77/2", oISSUE_PAYLOAD, oCOUNT); end
    iISSUE_BUSY = 1'b0;
    tick();
    checks++; if (oISSUE_PAYLOAD !== 64'h66 || oCOUNT !== 4'd1) begin errors++; $display("[TB] FAIL busy_next got %h/%0d want 66/1", oISSUE_PAYLOAD, oCOUNT); end
    tick();
    checks++; if (oCOUNT !== 4'd0) begin errors++; $display("[TB] FAIL busy_drain got %0d want 0", oCOUNT); end
  endtask

  task automatic test_fill();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applySlot0(1'b1, 64'h100 + 64'(2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
      applySlot1(1'b1, 64'h101 + 64'(2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
      tick();
    end
    checks++; if (oCOUNT !== 4'd8 || oFULL !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %0d/%b want 8/1", oCOUNT, oFULL); end
    applySlot0(1'b1, 64'hDEAD, 1'b1, 6'd0, 1'b1, 6'd0);
    applySlot1(1'b1, 64'hBEEF, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    clearInputs();
    checks++; if (oCOUNT !== 4'd8) begin errors++; $display("[TB] FAIL fill_overflow got %0d want 8", oCOUNT); end
    checks++; if (oISSUE_PAYLOAD !== 64'h100) begin errors++; $display("[TB] FAIL fill_head got %h want 100", oISSUE_PAYLOAD); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (oISSUE_VALID !== 1'b1 || oISSUE_PAYLOAD !== 64'h100 + 64'(i)) begin errors++; $display("[TB] FAIL fill_order[%0d] got %b/%h want 1/%h", i, oISSUE_VALID, oISSUE_PAYLOAD, 64'h100 + 64'(i)); end
      checks++; if (oCOUNT !== 4'(8 - i) || oFULL !== ((8 - i) >= 7)) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d/%b want %0d/%b", i, oCOUNT, oFULL, 8 - i, (8 - i) >= 7); end
      tick();
    end
    checks++; if (oCOUNT !== 4'd0 || oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL fill_drain got %0d/%b want 0/0", oCOUNT, oISSUE_VALID); end
  endtask

  task automatic test_back_to_back();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applySlot0(1'b1, 64'h200 + 64'(2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
      applySlot1(1'b1, 64'h201 + 64'(2 * i), 1'b1, 6'd0, 1'b1, 6'd0);
      tick();
    end
    applySlot0(1'b1, 64'h206, 1'b1, 6'd0, 1'b1, 6'd0);
    applySlot1(1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    checks++; if (oCOUNT !== 4'd7 || oFULL !== 1'b1) begin errors++; $display("[TB] FAIL b2b_seven got %0d/%b want 7/1", oCOUNT, oFULL); end
    iISSUE_BUSY = 1'b0;
    applySlot0(1'b1, 64'h207, 1'b1, 6'd0, 1'b1, 6'd0);
    applySlot1(1'b1, 64'h208, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    #1;
    checks++; if (oCOUNT !== 4'd8 || oFULL !== 1'b1) begin errors++; $display("[TB] FAIL b2b_count got %0d/%b want 8/1", oCOUNT, oFULL); end
    iISSUE_BUSY = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (oISSUE_VALID !== 1'b1 || oISSUE_PAYLOAD !== 64'h200 + 64'(i)) begin errors++; $display("[TB] FAIL b2b_order[%0d] got %b/%h want 1/%h", i, oISSUE_VALID, oISSUE_PAYLOAD, 64'h200 + 64'(i)); end
      tick();
    end
    checks++; if (oCOUNT !== 4'd0) begin errors++; $display("[TB] FAIL b2b_drain got %0d want 0", oCOUNT); end
  endtask

  task automatic test_alloc_wakeup();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    applySlot0(1'b1, 64'h33, 1'b1, 6'd0, 1'b0, 6'd3);
    iWAKEUP_1_VALID = 1'b1;
    iWAKEUP_1_TAG   = 6'd3;
    tick();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    #1;
    checks++; if (oISSUE_VALID !== 1'b1 || oISSUE_PAYLOAD !== 64'h33) begin errors++; $display("[TB] FAIL allocwake got %b/%h want 1/33", oISSUE_VALID, oISSUE_PAYLOAD); end
    applySlot1(1'b1, 64'h44, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    applySlot1(1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0);
    checks++; if (oCOUNT !== 4'd2) begin errors++; $display("[TB] FAIL slot1_alone got %0d want 2", oCOUNT); end
    iISSUE_BUSY = 1'b0;
    tick();
    checks++; if (oISSUE_PAYLOAD !== 64'h44 || oCOUNT !== 4'd1) begin errors++; $display("[TB] FAIL slot1_order got %h/%0d want 44/1", oISSUE_PAYLOAD, oCOUNT); end
    tick();
  endtask

  task automatic test_flush();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applySlot0(1'b1, 64'h300 + 64'(i), 1'b1, 6'd0, 1'b1, 6'd0);
      applySlot1(1'b1, 64'h310 + 64'(i), 1'b1, 6'd0, 1'b1, 6'd0);
      tick();
    end
    checks++; if (oCOUNT !== 4'd4) begin errors++; $display("[TB] FAIL flush_pre got %0d want 4", oCOUNT); end
    iISSUE_BUSY = 1'b0;
    iFLUSH      = 1'b1;
    tick();
    clearInputs();
    #1;
    checks++; if (oCOUNT !== 4'd0 || oISSUE_VALID !== 1'b0 || oFULL !== 1'b0) begin errors++; $display("[TB] FAIL flush_post got %0d/%b/%b want 0/0/0", oCOUNT, oISSUE_VALID, oFULL); end
  endtask

  task automatic test_mid_reset();
    clearInputs();
    iISSUE_BUSY = 1'b1;
    applySlot0(1'b1, 64'h400, 1'b1, 6'd0, 1'b1, 6'd0);
    applySlot1(1'b1, 64'h401, 1'b1, 6'd0, 1'b1, 6'd0);
    tick();
    iRESET_SYNC = 1'b1;
    iFLUSH      = 1'b0;
    tick();
    clearInputs();
    #1;
    checks++; if (oCOUNT !== 4'd0 || oISSUE_VALID !== 1'b0) begin errors++; $display("[TB] FAIL midreset got %0d/%b want 0/0", oCOUNT, oISSUE_VALID); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup_order();
    test_busy_wakeup();
    test_fill();
    test_back_to_back();
    test_alloc_wakeup();
    test_flush();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
